fpnew_opgroup_out_arb: RTL and testbench

- Downstream stage of the per-format operation-group slices: collects result/status/ext-bit/tag from NumInputs format slices.
- Round-robin arbitrates among them and presents one registered result per cycle to the FPU top-level output mux.
- Full throughput, 1-cycle latency, one output register stage with valid/ready backpressure.

---
 rtl/fpnew_pkg.sv | 16 +
 rtl/fpnew_rr_arb_core.sv | 32 +++
 rtl/fpnew_opgroup_out_arb.sv | 90 +++++++++
 tb/tb_fpnew_opgroup_out_arb.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// fpnew_pkg: shared FPU types and the round-robin pointer-wrap helper
package fpnew_pkg;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fpnew_rr_arb_core.sv
// fpnew_rr_arb_core: combinational round-robin grant starting at rr_ptr_i
module fpnew_rr_arb_core #(
    parameter int unsigned NumInputs = 5,
    parameter int unsigned IdxWidth  = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
    input  logic [NumInputs-1:0] req_i,
    input  logic [IdxWidth-1:0]  rr_ptr_i,
    input  logic                 en_i,
    output logic [NumInputs-1:0] gnt_o,
    output logic [IdxWidth-1:0]  idx_o
);

    logic        found;
    logic [31:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int unsigned k = 0; k < NumInputs; k++) begin
            j = 32'(rr_ptr_i) + k;
            if (j >= NumInputs) j = j - NumInputs;
            if (en_i && !found && req_i[j[IdxWidth-1:0]]) begin
                found                    = 1'b1;
                gnt_o[j[IdxWidth-1:0]]   = 1'b1;
                idx_o                    = j[IdxWidth-1:0];
            end
        end
    end

endmodule

// File: rtl/fpnew_opgroup_out_arb.sv
// fpnew_opgroup_out_arb: round-robin merge of format-slice results into one registered output
module fpnew_opgroup_out_arb
    import fpnew_pkg::*;
#(
    parameter int unsigned NumInputs = 5,
    parameter int unsigned Width     = 64,
    parameter type         TagType   = logic,
    localparam int unsigned IdxWidth = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic    [NumInputs-1:0]         in_valid_i,
    output logic    [NumInputs-1:0]         in_ready_o,
    input  logic    [NumInputs-1:0][Width-1:0] result_i,
    input  status_t [NumInputs-1:0]         status_i,
    input  logic    [NumInputs-1:0]         ext_bit_i,
    input  TagType  [NumInputs-1:0]         tag_i,
    input  logic    [NumInputs-1:0]         busy_i,
    input  logic                            flush_i,
    output logic    [Width-1:0]             result_o,
    output status_t                         status_o,
    output logic                            extension_bit_o,
    output TagType                          tag_o,
    output logic    [IdxWidth-1:0]          src_idx_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic                            busy_o
);

    logic                 out_valid_q;
    logic [Width-1:0]     result_q;
    status_t              status_q;
    logic                 ext_bit_q;
    TagType               tag_q;
    logic [IdxWidth-1:0]  src_idx_q, rr_ptr_q, rr_ptr_d;
    logic [NumInputs-1:0] gnt;
    logic [IdxWidth-1:0]  gnt_idx;
    logic                 stage_ready, hs;

    assign stage_ready = ~out_valid_q | out_ready_i;

    // no grants while in reset so slices held in reset never see a handshake
    fpnew_rr_arb_core #(
        .NumInputs(NumInputs),
        .IdxWidth (IdxWidth)
    ) i_arb (
        .req_i   (in_valid_i),
        .rr_ptr_i(rr_ptr_q),
        .en_i    (stage_ready & ~flush_i & rst_ni),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx)
    );

    assign hs         = |gnt;
    assign in_ready_o = gnt;
    assign rr_ptr_d   = IdxWidth'(rr_next(32'(gnt_idx), NumInputs));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            status_q    <= '0;
            ext_bit_q   <= 1'b0;
            tag_q       <= '0;
            src_idx_q   <= '0;
            rr_ptr_q    <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (hs) begin
            out_valid_q <= 1'b1;
            result_q    <= result_i[gnt_idx];
            status_q    <= status_i[gnt_idx];
            ext_bit_q   <= ext_bit_i[gnt_idx];
            tag_q       <= tag_i[gnt_idx];
            src_idx_q   <= gnt_idx;
            rr_ptr_q    <= rr_ptr_d;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o     = out_valid_q;
    assign result_o        = result_q;
    assign status_o        = status_q;
    assign extension_bit_o = ext_bit_q;
    assign tag_o           = tag_q;
    assign src_idx_o       = src_idx_q;
    assign busy_o          = (|busy_i) | out_valid_q;

endmodule

// File: tb/tb_fpnew_opgroup_out_arb.sv
// tb_fpnew_opgroup_out_arb: scoreboard bench for the output arbiter
module tb_fpnew_opgroup_out_arb;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [4:0]      in_valid_i = '0;
    logic [4:0]      in_ready_o;
    logic [4:0][63:0] result_i = '0;
    logic [4:0][4:0] status_i = '0;
    logic [4:0]      ext_bit_i = '0;
    logic [4:0][7:0] tag_i = '0;
    logic [4:0]      busy_i = '0;
    logic            flush_i = 1'b0;
    logic [63:0]     result_o;
    logic [4:0]      status_o;
    logic            extension_bit_o;
    logic [7:0]      tag_o;
    logic [2:0]      src_idx_o;
    logic            out_valid_o;
    logic            out_ready_i = 1'b1;
    logic            busy_o;

    typedef struct {
        logic [63:0] r;
        logic [4:0]  s;
        logic        x;
        logic [7:0]  t;
        logic [2:0]  idx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   mrr = 0;

    always #5 clk_i = ~clk_i;

    fpnew_opgroup_out_arb #(
        .NumInputs(5),
        .Width    (64),
        .TagType  (logic [7:0])
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .result_i       (result_i),
        .status_i       (status_i),
        .ext_bit_i      (ext_bit_i),
        .tag_i          (tag_i),
        .busy_i         (busy_i),
        .flush_i        (flush_i),
        .result_o       (result_o),
        .status_o       (status_o),
        .extension_bit_o(extension_bit_o),
        .tag_o          (tag_o),
        .src_idx_o      (src_idx_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .busy_o         (busy_o)
    );

    // reference model: checks every cycle, pushes on predicted handshake, pops on consume/flush
    always @(negedge clk_i) begin
        logic       mvalid, found;
        logic [4:0] egnt;
        int         gidx, j;
        exp_t       e, ne;
        if (!rst_ni) begin
            sb.delete();
            mrr = 0;
            n_checks++;
            if (in_ready_o !== 5'b0) begin n_fail++; $display("FAIL sb_rst_ready: got %b want 00000", in_ready_o); end
        end else begin
            mvalid = sb.size() > 0;
            n_checks++;
            if (out_valid_o !== mvalid) begin n_fail++; $display("FAIL sb_valid: got %b want %b", out_valid_o, mvalid); end
            n_checks++;
            if (busy_o !== ((|busy_i) | mvalid)) begin n_fail++; $display("FAIL sb_busy: got %b want %b", busy_o, (|busy_i) | mvalid); end
            if (mvalid) begin
                e = sb[0];
                n_checks++;
                if (result_o !== e.r || status_o !== e.s || extension_bit_o !== e.x || tag_o !== e.t || src_idx_o !== e.idx) begin
                    n_fail++;
                    $display("FAIL sb_data: got r=%h s=%b x=%b t=%h i=%0d want r=%h s=%b x=%b t=%h i=%0d",
                             result_o, status_o, extension_bit_o, tag_o, src_idx_o, e.r, e.s, e.x, e.t, e.idx);
                end
            end
            egnt = '0;
            gidx = 0;
            found = 1'b0;
            if ((!mvalid || out_ready_i) && !flush_i)
                for (int k = 0; k < 5; k++) begin
                    j = (mrr + k) % 5;
                    if (!found && in_valid_i[j]) begin found = 1'b1; egnt[j] = 1'b1; gidx = j; end
                end
            n_checks++;
            if (in_ready_o !== egnt) begin n_fail++; $display("FAIL sb_grant: got %b want %b", in_ready_o, egnt); end
            if (flush_i) begin
                if (mvalid) void'(sb.pop_front());
            end else begin
                if (mvalid && out_ready_i) void'(sb.pop_front());
                if (found) begin
                    ne.r = result_i[gidx]; ne.s = status_i[gidx]; ne.x = ext_bit_i[gidx];
                    ne.t = tag_i[gidx]; ne.idx = 3'(gidx);
                    sb.push_back(ne);
                    mrr = (gidx + 1) % 5;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        in_valid_i = 5'b11111;
        repeat (2) begin
            @(negedge clk_i);
            n_checks++;
            if (in_ready_o !== 5'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 00000", in_ready_o); end
        end
        tick();
        rst_ni = 1'b1;
        in_valid_i = '0;
        @(negedge clk_i);
        n_checks++;
        if (out_valid_o !== 1'b0 || result_o !== 64'h0 || status_o !== 5'h0 || tag_o !== 8'h0 || src_idx_o !== 3'd0 || extension_bit_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got v=%b r=%h s=%b t=%h i=%0d x=%b want all zero", out_valid_o, result_o, status_o, tag_o, src_idx_o, extension_bit_o);
        end
    endtask

    task automatic test_single;
        for (int i = 0; i < 5; i++) begin
            result_i[i] = 64'h1000 + 64'(i);
            tag_i[i] = 8'(16 + i);
            status_i[i] = 5'(i);
            ext_bit_i[i] = i[0];
        end
        result_i[2] = 64'hDEAD_BEEF;
        status_i[2] = 5'b00001;
        tag_i[2] = 8'd7;
        out_ready_i = 1'b1;
        in_valid_i = 5'b00100;
        @(negedge clk_i);
        n_checks++;
        if (in_ready_o !== 5'b00100) begin n_fail++; $display("FAIL single_ready: got %b want 00100", in_ready_o); end
        tick();
        in_valid_i = '0;
        @(negedge clk_i);
        n_checks++;
        if (out_valid_o !== 1'b1 || result_o !== 64'hDEAD_BEEF || status_o !== 5'b00001 || tag_o !== 8'd7 || src_idx_o !== 3'd2) begin
            n_fail++;
            $display("FAIL single_out: got v=%b r=%h s=%b t=%0d i=%0d want v=1 r=deadbeef s=00001 t=7 i=2", out_valid_o, result_o, status_o, tag_o, src_idx_o);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        out_ready_i = 1'b0;
        in_valid_i = 5'b00001;
        tick();
        in_valid_i = '0;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid_valid: got %b want 0", out_valid_o); end
    endtask

    task automatic test_round_robin;
        out_ready_i = 1'b1;
        in_valid_i = 5'b11111;
        @(posedge clk_i);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk_i);
            n_checks++;
            if (out_valid_o !== 1'b1 || src_idx_o !== 3'(k % 5)) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got v=%b i=%0d want v=1 i=%0d", k, out_valid_o, src_idx_o, k % 5);
            end
        end
        tick();
        in_valid_i = '0;
        tick();
    endtask

    task automatic test_backpressure;
        result_i[1] = 64'hB1;
        result_i[3] = 64'hB3;
        out_ready_i = 1'b0;
        in_valid_i = 5'b00010;
        @(negedge clk_i);
        n_checks++;
        if (in_ready_o !== 5'b00010) begin n_fail++; $display("FAIL bp_first_ready: got %b want 00010", in_ready_o); end
        tick();
        in_valid_i = 5'b01000;
        repeat (3) begin
            @(negedge clk_i);
            n_checks++;
            if (in_ready_o !== 5'b0 || out_valid_o !== 1'b1 || src_idx_o !== 3'd1 || result_o !== 64'hB1) begin
                n_fail++;
                $display("FAIL bp_hold: got rdy=%b v=%b i=%0d r=%h want rdy=00000 v=1 i=1 r=b1", in_ready_o, out_valid_o, src_idx_o, result_o);
            end
            tick();
        end
        out_ready_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (in_ready_o !== 5'b01000) begin n_fail++; $display("FAIL bp_release_ready: got %b want 01000", in_ready_o); end
        tick();
        in_valid_i = '0;
        @(negedge clk_i);
        n_checks++;
        if (out_valid_o !== 1'b1 || src_idx_o !== 3'd3 || result_o !== 64'hB3) begin
            n_fail++;
            $display("FAIL bp_next_out: got v=%b i=%0d r=%h want v=1 i=3 r=b3", out_valid_o, src_idx_o, result_o);
        end
        tick();
    endtask

    task automatic test_flush;
        out_ready_i = 1'b0;
        in_valid_i = 5'b00100;
        tick();
        in_valid_i = 5'b10001;
        flush_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (in_ready_o !== 5'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 00000", in_ready_o); end
        tick();
        flush_i = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 5'b10000) begin
            n_fail++;
            $display("FAIL flush_after: got v=%b rdy=%b want v=0 rdy=10000", out_valid_o, in_ready_o);
        end
        tick();
        @(negedge clk_i);
        n_checks++;
        if (in_ready_o !== 5'b00001 || src_idx_o !== 3'd4) begin
            n_fail++;
            $display("FAIL flush_order: got rdy=%b i=%0d want rdy=00001 i=4", in_ready_o, src_idx_o);
        end
        tick();
        in_valid_i = '0;
        @(negedge clk_i);
        n_checks++;
        if (src_idx_o !== 3'd0 || out_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_wrap: got v=%b i=%0d want v=1 i=0", out_valid_o, src_idx_o); end
        tick();
    endtask

    task automatic test_busy;
        busy_i = 5'b01000;
        @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL busy_slice: got %b want 1", busy_o); end
        tick();
        busy_i = '0;
        out_ready_i = 1'b0;
        in_valid_i = 5'b00010;
        tick();
        in_valid_i = '0;
        @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b1 || out_valid_o !== 1'b1) begin n_fail++; $display("FAIL busy_valid: got busy=%b v=%b want 1 1", busy_o, out_valid_o); end
        out_ready_i = 1'b1;
        tick();
        @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL busy_idle: got %b want 0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_busy();
        @(negedge clk_i);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_empty: got %0d pending want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
